sync_fifo_ctrl: RTL and testbench

SYNC_FIFO_CTRL -- requirements
Module: SYNC_FIFO_CTRL

---
 rtl/sync_fifo_ctrl.sv | 94 +++++++++
 tb/tb_sync_fifo_ctrl.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_ctrl.sv
// Synchronous FIFO controller driving an external simple dual-port RAM.
// Tracks pointers, occupancy and sticky error flags, and qualifies RAM read data.
module sync_fifo_ctrl #(
    parameter int unsigned DATA_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned RAM_LATENCY = 1
) (
    input  logic                  CLK_I,
    input  logic                  RST_I,
    input  logic                  WR_I,
    input  logic [DATA_WIDTH-1:0] WDATA_I,
    input  logic                  RD_I,
    output logic                  FULL_O,
    output logic                  EMPTY_O,
    output logic [ADDR_WIDTH:0]   COUNT_O,
    output logic                  OVF_O,
    output logic                  UDF_O,
    output logic [ADDR_WIDTH-1:0] WADDR_O,
    output logic                  WENABLE_O,
    output logic [DATA_WIDTH-1:0] WDATA_O,
    output logic [ADDR_WIDTH-1:0] RADDR_O,
    output logic                  RENABLE_O,
    input  logic [DATA_WIDTH-1:0] RDATA_I,
    output logic [DATA_WIDTH-1:0] RDATA_O,
    output logic                  RVALID_O
);

    localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH     = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0]  wptr;
    logic [ADDR_WIDTH-1:0]  rptr;
    logic [CNT_WIDTH-1:0]   count_nxt;
    logic                   push;
    logic                   pop;
    logic [RAM_LATENCY-1:0] rv_pipe;

    // Request qualification uses the registered (pre-edge) flags only.
    always_comb begin
        push      = WR_I & ~FULL_O & ~RST_I;
        pop       = RD_I & ~EMPTY_O & ~RST_I;
        count_nxt = COUNT_O;
        case ({push, pop})
            2'b10:   count_nxt = COUNT_O + CNT_WIDTH'(1);
            2'b01:   count_nxt = COUNT_O - CNT_WIDTH'(1);
            default: count_nxt = COUNT_O;
        endcase
    end

    assign WENABLE_O = push;
    assign WADDR_O   = wptr;
    assign WDATA_O   = WDATA_I;
    assign RENABLE_O = pop;
    assign RADDR_O   = rptr;
    assign RDATA_O   = RDATA_I;

    // Masking by reset keeps a read issued just before reset from surfacing.
    assign RVALID_O  = rv_pipe[RAM_LATENCY-1] & ~RST_I;

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            wptr    <= '0;
            rptr    <= '0;
            COUNT_O <= '0;
            FULL_O  <= 1'b0;
            EMPTY_O <= 1'b1;
            OVF_O   <= 1'b0;
            UDF_O   <= 1'b0;
            rv_pipe <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + ADDR_WIDTH'(1);
            end
            if (pop) begin
                rptr <= rptr + ADDR_WIDTH'(1);
            end
            COUNT_O <= count_nxt;
            FULL_O  <= (count_nxt == CNT_WIDTH'(DEPTH));
            EMPTY_O <= (count_nxt == '0);
            if (WR_I && FULL_O) begin
                OVF_O <= 1'b1;
            end
            if (RD_I && EMPTY_O) begin
                UDF_O <= 1'b1;
            end
            // Read-valid delay line matches the RAM read latency.
            rv_pipe[0] <= pop;
            for (int i = 1; i < int'(RAM_LATENCY); i++) begin
                rv_pipe[i] <= rv_pipe[i-1];
            end
        end
    end

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Randomized and directed bench for sync_fifo_ctrl against a queue-based FIFO model.
module tb_sync_fifo_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int LAT   = 1;
    localparam int DEPTH = 16;

    logic          clk;
    logic          rst;
    logic          wr;
    logic          rd;
    logic [DW-1:0] wdata;
    logic          full;
    logic          empty;
    logic [AW:0]   count;
    logic          ovf;
    logic          udf;
    logic [AW-1:0] waddr;
    logic          wen;
    logic [DW-1:0] wdata_o;
    logic [AW-1:0] raddr;
    logic          ren;
    logic [DW-1:0] ram_q;
    logic [DW-1:0] rdata;
    logic          rvalid;

    sync_fifo_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RAM_LATENCY(LAT)) dut (
        .CLK_I(clk), .RST_I(rst), .WR_I(wr), .WDATA_I(wdata), .RD_I(rd),
        .FULL_O(full), .EMPTY_O(empty), .COUNT_O(count), .OVF_O(ovf), .UDF_O(udf),
        .WADDR_O(waddr), .WENABLE_O(wen), .WDATA_O(wdata_o),
        .RADDR_O(raddr), .RENABLE_O(ren), .RDATA_I(ram_q),
        .RDATA_O(rdata), .RVALID_O(rvalid)
    );

    // Simple dual-port RAM with one cycle read latency.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (wen) mem[waddr] <= wdata_o;
        if (ren) ram_q <= mem[raddr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    // Reference model state
    int q[$];
    int wptr_m = 0;
    int rptr_m = 0;
    bit ovf_m = 1'b0;
    bit udf_m = 1'b0;
    bit rv_m[LAT];
    int rd_m[LAT];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d required %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        wptr_m = 0;
        rptr_m = 0;
        ovf_m  = 1'b0;
        udf_m  = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            rv_m[i] = 1'b0;
            rd_m[i] = 0;
        end
    endtask

    // One clock cycle: drive, compare all outputs, advance model on the edge.
    task automatic step(input bit w, input int d, input bit r, input bit rs);
        bit full_m, empty_m, push_m, pop_m, rv_exp;
        wr    = w;
        wdata = DW'(d);
        rd    = r;
        rst   = rs;
        #2;
        full_m  = (q.size() == DEPTH);
        empty_m = (q.size() == 0);
        push_m  = w && !full_m && !rs;
        pop_m   = r && !empty_m && !rs;
        rv_exp  = rv_m[LAT-1] && !rs;
        if (chk_en) begin
            chk("wenable", wen, push_m);
            chk("renable", ren, pop_m);
            if (push_m) begin
                chk("waddr", waddr, wptr_m);
                chk("wdata", wdata_o, d & 255);
            end
            if (pop_m) chk("raddr", raddr, rptr_m);
            chk("count", count, q.size());
            chk("full", full, full_m);
            chk("empty", empty, empty_m);
            chk("ovf", ovf, ovf_m);
            chk("udf", udf, udf_m);
            chk("rvalid", rvalid, rv_exp);
            if (rv_exp) chk("rdata", rdata, rd_m[LAT-1]);
        end
        @(posedge clk);
        if (rs) begin
            model_reset();
        end else begin
            if (w && full_m)  ovf_m = 1'b1;
            if (r && empty_m) udf_m = 1'b1;
            for (int i = LAT-1; i > 0; i--) begin
                rv_m[i] = rv_m[i-1];
                rd_m[i] = rd_m[i-1];
            end
            rv_m[0] = pop_m;
            rd_m[0] = pop_m ? q.pop_front() : 0;
            if (pop_m)  rptr_m = (rptr_m + 1) % DEPTH;
            if (push_m) begin
                q.push_back(d & 255);
                wptr_m = (wptr_m + 1) % DEPTH;
            end
        end
        #1;
    endtask

    initial begin
        int pw, pr;
        model_reset();
        wr = 0; rd = 0; rst = 1; wdata = '0;
        repeat (2) step(0, 0, 0, 1);
        chk_en = 1'b1;
        step(0, 0, 0, 1);

        // Idle after reset
        repeat (3) step(0, 0, 0, 0);
        chk("idle_empty", empty, 1);
        chk("idle_full", full, 0);
        chk("idle_count", count, 0);
        chk("idle_rvalid", rvalid, 0);

        // Fill to full, then overflow attempt
        for (int i = 0; i < 16; i++) step(1, 70 + 2*i, 0, 0);
        chk("fill_full", full, 1);
        chk("fill_count", count, 16);
        step(1, 200, 0, 0);
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 16);

        // Back-to-back drain, data in push order
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 1, 0);
            chk("drain_rvalid", rvalid, 1);
            chk("drain_rdata", rdata, 70 + 2*i);
        end
        step(0, 0, 0, 0);
        chk("drain_empty", empty, 1);
        chk("drain_rvalid_off", rvalid, 0);
        step(0, 0, 1, 0);
        chk("udf_set", udf, 1);
        step(0, 0, 0, 1);

        // Streaming with one-word lead; pointers wrap several times
        step(1, 3, 0, 0);
        for (int i = 1; i < 40; i++) begin
            step(1, (i*7 + 3) & 255, 1, 0);
            chk("stream_count", count, 1);
            chk("stream_rdata", rdata, ((i-1)*7 + 3) & 255);
        end
        step(0, 0, 1, 0);
        step(0, 0, 0, 0);

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) step(1, i + 1, 0, 0);
        step(1, 99, 1, 0);
        chk("fullboth_count", count, 15);
        chk("fullboth_full", full, 0);
        repeat (15) step(0, 0, 1, 0);
        step(0, 0, 0, 0);
        // Empty with simultaneous push and pop
        step(1, 9, 1, 0);
        chk("emptyboth_count", count, 1);
        chk("emptyboth_empty", empty, 0);
        step(0, 0, 1, 0);
        chk("emptyboth_rdata", rdata, 9);
        step(0, 0, 0, 0);

        // Reset right after a pop with five words stored
        step(0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 40 + i, 0, 0);
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        chk("rst_rvalid", rvalid, 0);
        step(0, 0, 0, 0);
        chk("rst_empty", empty, 1);
        chk("rst_count", count, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_udf", udf, 0);
        chk("rst_rvalid2", rvalid, 0);

        // Randomized traffic with drifting fill bias and rare resets
        for (int blk = 0; blk < 12; blk++) begin
            pw = (blk % 3 == 0) ? 80 : (blk % 3 == 1) ? 30 : 55;
            pr = (blk % 3 == 0) ? 30 : (blk % 3 == 1) ? 80 : 55;
            for (int c = 0; c < 150; c++) begin
                step(($urandom % 100) < pw, $urandom % 256, ($urandom % 100) < pr,
                     ($urandom % 200) == 0);
            end
        end
        step(0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
